// File: rtl/unit_prop_controller_pkg.sv
// Shared types for the unit propagation controller.
// Purpose : literal / clause / formula containers, the BCP result code and
//           the sizing constants used by the controller, its clause finder
//           and anything talking to Propagate_literal.
// Ports   : none (package).
package unit_prop_controller_pkg;

    localparam int NUM_VARS    = 8;
    localparam int MAX_CLAUSES = 10;
    localparam int MAX_LITS    = 3;

    // A literal is a variable index plus its polarity (1 = positive).
    // Variable 0 is reserved and never legitimately assigned.
    typedef struct packed {
        logic       pol;
        logic [2:0] vid;
    } lit;

    typedef struct packed {
        logic [1:0]              count;
        lit [MAX_LITS-1:0]       lits;
    } clause;

    typedef struct packed {
        logic [3:0]              count;
        clause [MAX_CLAUSES-1:0] clauses;
    } formula;

    typedef enum logic [2:0] {
        RES_NONE   = 3'd0,
        RES_SAT    = 3'd1,
        RES_UNSAT  = 3'd2,
        RES_STABLE = 3'd3,
        RES_ERR    = 3'd4
    } res_t;

    localparam lit ZERO_LIT = '0;

endpackage

// File: rtl/unit_prop_controller_finder.sv
// Combinational unit-clause finder.
// Purpose : looks at the live clauses of a formula (index < count) and
//           reports whether any is empty and which is the lowest-index unit
//           clause that is not masked off by the caller.
// Ports   : f          in  formula being scanned
//           skip_mask  in  clause indices the caller wants ignored as units
//           has_empty  out some live clause has no literals
//           has_unit   out an unmasked live unit clause exists
//           unit_idx   out index of the lowest such clause
//           unit_lit   out its single literal (lits[0])
module unit_clause_finder
    import unit_prop_controller_pkg::*;
(
    input  formula                 f,
    input  logic [MAX_CLAUSES-1:0] skip_mask,
    output logic                   has_empty,
    output logic                   has_unit,
    output logic [3:0]             unit_idx,
    output lit                     unit_lit
);

    // Only lits[0] of a unit clause matters; the remaining literal slots are
    // folded into this sink on purpose.
    logic unused_f_bits;
    assign unused_f_bits = ^f;

    // Walk clauses upward; the first unmasked unit found is kept so the
    // lowest index wins.
    always_comb begin
        has_empty = 1'b0;
        has_unit  = 1'b0;
        unit_idx  = '0;
        unit_lit  = ZERO_LIT;
        for (int i = 0; i < MAX_CLAUSES; i++) begin
            if (4'(i) < f.count) begin
                if (f.clauses[i].count == 2'd0) begin
                    has_empty = 1'b1;
                end else if (f.clauses[i].count == 2'd1 && !skip_mask[i] && !has_unit) begin
                    has_unit = 1'b1;
                    unit_idx = 4'(i);
                    unit_lit = f.clauses[i].lits[0];
                end
            end
        end
    end

endmodule

// File: rtl/unit_prop_controller.sv
// Boolean constraint propagation sequencer.
// Purpose : repeatedly finds a unit clause, hands its literal to the single
//           Propagate_literal instance, waits for it and records the
//           assignment, until SAT, conflict, no unit left, or a limit hits.
// Ports   : clock, reset (sync, active-high); start / in_formula request;
//           busy, done, result, out_formula, assign_set, assign_val,
//           prop_count report; pl_* is the Propagate_literal handshake.
module unit_prop_controller
    import unit_prop_controller_pkg::*;
#(
    parameter int MAX_ITER   = 10,
    parameter int PL_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  formula              in_formula,
    output logic                busy,
    output logic                done,
    output res_t                result,
    output formula              out_formula,
    output logic [NUM_VARS-1:0] assign_set,
    output logic [NUM_VARS-1:0] assign_val,
    output logic [3:0]          prop_count,
    output logic                pl_find,
    output lit                  pl_lit,
    output formula              pl_formula,
    input  logic                pl_ended,
    input  logic                pl_empty_clause,
    input  logic                pl_empty_formula,
    input  formula              pl_out_formula
);

    localparam logic [7:0] ITER_LIMIT   = 8'(MAX_ITER);
    localparam logic [7:0] TIMEOUT_LAST = 8'(PL_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, CHECK, FIN} state_t;

    state_t                 state_q, state_d;
    formula                 work_f_q, work_f_d;
    formula                 out_formula_q, out_formula_d;
    formula                 pl_res_f_q, pl_res_f_d;
    logic                   pl_ec_q, pl_ec_d;
    logic                   pl_ef_q, pl_ef_d;
    logic [NUM_VARS-1:0]    assign_set_q, assign_set_d;
    logic [NUM_VARS-1:0]    assign_val_q, assign_val_d;
    logic [3:0]             prop_count_q, prop_count_d;
    logic [7:0]             iter_q, iter_d;
    logic [7:0]             timeout_q, timeout_d;
    res_t                   result_q, result_d;
    lit                     unit_lit_q, unit_lit_d;
    logic [MAX_CLAUSES-1:0] skip_q, skip_d;

    logic       has_empty;
    logic       has_unit;
    logic [3:0] unit_idx;
    lit         unit_lit;

    // Units whose variable already holds the same value are masked here one
    // at a time, so the finder then offers the next unit on the following
    // SCAN cycle.
    unit_clause_finder u_finder (
        .f         (work_f_q),
        .skip_mask (skip_q),
        .has_empty (has_empty),
        .has_unit  (has_unit),
        .unit_idx  (unit_idx),
        .unit_lit  (unit_lit)
    );

    // State register; reset beats start, pl_ended and everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            work_f_q      <= '0;
            out_formula_q <= '0;
            pl_res_f_q    <= '0;
            pl_ec_q       <= 1'b0;
            pl_ef_q       <= 1'b0;
            assign_set_q  <= '0;
            assign_val_q  <= '0;
            prop_count_q  <= '0;
            iter_q        <= '0;
            timeout_q     <= '0;
            result_q      <= RES_NONE;
            unit_lit_q    <= ZERO_LIT;
            skip_q        <= '0;
        end else begin
            state_q       <= state_d;
            work_f_q      <= work_f_d;
            out_formula_q <= out_formula_d;
            pl_res_f_q    <= pl_res_f_d;
            pl_ec_q       <= pl_ec_d;
            pl_ef_q       <= pl_ef_d;
            assign_set_q  <= assign_set_d;
            assign_val_q  <= assign_val_d;
            prop_count_q  <= prop_count_d;
            iter_q        <= iter_d;
            timeout_q     <= timeout_d;
            result_q      <= result_d;
            unit_lit_q    <= unit_lit_d;
            skip_q        <= skip_d;
        end
    end

    // Next-state logic. Propagate_literal results are captured on the cycle
    // pl_ended is seen so CHECK does not depend on them staying valid.
    always_comb begin
        state_d       = state_q;
        work_f_d      = work_f_q;
        out_formula_d = out_formula_q;
        pl_res_f_d    = pl_res_f_q;
        pl_ec_d       = pl_ec_q;
        pl_ef_d       = pl_ef_q;
        assign_set_d  = assign_set_q;
        assign_val_d  = assign_val_q;
        prop_count_d  = prop_count_q;
        iter_d        = iter_q;
        timeout_d     = timeout_q;
        result_d      = result_q;
        unit_lit_d    = unit_lit_q;
        skip_d        = skip_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_f_d     = in_formula;
                    assign_set_d = '0;
                    assign_val_d = '0;
                    prop_count_d = '0;
                    iter_d       = '0;
                    skip_d       = '0;
                    result_d     = RES_NONE;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (work_f_q.count == 4'd0) begin
                    result_d = RES_SAT;
                    state_d  = FIN;
                end else if (has_empty) begin
                    result_d = RES_UNSAT;
                    state_d  = FIN;
                end else if (has_unit) begin
                    if (unit_lit.vid == 3'd0) begin
                        result_d = RES_ERR;
                        state_d  = FIN;
                    end else if (assign_set_q[unit_lit.vid]) begin
                        if (assign_val_q[unit_lit.vid] != unit_lit.pol) begin
                            result_d = RES_UNSAT;
                            state_d  = FIN;
                        end else begin
                            skip_d = skip_q | ({{(MAX_CLAUSES-1){1'b0}}, 1'b1} << unit_idx);
                        end
                    end else begin
                        unit_lit_d = unit_lit;
                        state_d    = ISSUE;
                    end
                end else begin
                    result_d = RES_STABLE;
                    state_d  = FIN;
                end
            end
            ISSUE: begin
                assign_set_d[unit_lit_q.vid] = 1'b1;
                assign_val_d[unit_lit_q.vid] = unit_lit_q.pol;
                if (iter_q != 8'hFF) begin
                    iter_d = iter_q + 8'd1;
                end
                // The ISSUE cycle already counts as one cycle of pl_find high.
                timeout_d = 8'd1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (pl_ended) begin
                    pl_res_f_d = pl_out_formula;
                    pl_ec_d    = pl_empty_clause;
                    pl_ef_d    = pl_empty_formula;
                    state_d    = CHECK;
                end else if (timeout_q >= TIMEOUT_LAST) begin
                    result_d = RES_ERR;
                    state_d  = FIN;
                end else begin
                    timeout_d = timeout_q + 8'd1;
                end
            end
            CHECK: begin
                work_f_d = pl_res_f_q;
                skip_d   = '0;
                if (prop_count_q != 4'hF) begin
                    prop_count_d = prop_count_q + 4'd1;
                end
                if (pl_ec_q) begin
                    result_d = RES_UNSAT;
                    state_d  = FIN;
                end else if (pl_ef_q) begin
                    result_d = RES_SAT;
                    state_d  = FIN;
                end else if (iter_q >= ITER_LIMIT) begin
                    result_d = RES_ERR;
                    state_d  = FIN;
                end else begin
                    state_d = SCAN;
                end
            end
            FIN: begin
                out_formula_d = work_f_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode straight from state so pl_find
    // drops the cycle after reset or as soon as WAIT is left.
    assign pl_find     = (state_q == ISSUE) || (state_q == WAIT);
    assign pl_lit      = unit_lit_q;
    assign pl_formula  = work_f_q;
    assign busy        = (state_q == SCAN) || (state_q == ISSUE) ||
                         (state_q == WAIT) || (state_q == CHECK);
    assign done        = (state_q == FIN);
    assign result      = result_q;
    assign out_formula = out_formula_q;
    assign assign_set  = assign_set_q;
    assign assign_val  = assign_val_q;
    assign prop_count  = prop_count_q;

endmodule
